// File: rtl/alu_bitfield_seq_pkg.sv
// ============================================================================
// Module      : alu_bitfield_seq_pkg
// Description : Shared op codes, FSM encodings, data width and op decode for
//               the iterative bitfield extract/insert unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_bitfield_seq_pkg;

    localparam int c_DATA_W = 32;

    localparam logic [1:0] c_OP_EXTRACT   = 2'b00;
    localparam logic [1:0] c_OP_INSERT    = 2'b01;
    localparam logic [1:0] c_OP_EXTRACT_S = 2'b10;
    localparam logic [1:0] c_OP_RSVD      = 2'b11;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_MASK  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    typedef struct packed {
        logic insert;
        logic err;
    } bfx_ctrl_t;

    // Anything that is not an insert runs down the extract path.
    function automatic bfx_ctrl_t decode_op(input logic [1:0] op);
        bfx_ctrl_t ctrl;
        ctrl = '0;
        case (op)
            c_OP_EXTRACT:   ctrl = '{insert: 1'b0, err: 1'b0};
            c_OP_INSERT:    ctrl = '{insert: 1'b1, err: 1'b0};
`ifdef ALU_BFX_SIGNED_EN
            c_OP_EXTRACT_S: ctrl = '{insert: 1'b0, err: 1'b0};
`else
            c_OP_EXTRACT_S: ctrl = '{insert: 1'b0, err: 1'b1};
`endif
            c_OP_RSVD:      ctrl = '{insert: 1'b0, err: 1'b1};
            default:        ctrl = '{insert: 1'b0, err: 1'b1};
        endcase
        return ctrl;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_bitfield_seq_if.sv
// ============================================================================
// Module      : alu_bitfield_seq_if
// Description : Request/response bundle of the bitfield unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_bitfield_seq_if;
    import alu_bitfield_seq_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [1:0]          in_op;
    logic [c_DATA_W-1:0] in_src;
    logic [c_DATA_W-1:0] in_dst;
    logic [4:0]          in_pos;
    logic [4:0]          in_size;
    logic                out_valid;
    logic                out_ready;
    logic [c_DATA_W-1:0] out_data;
    logic                out_err;
    logic                busy;

    modport master (
        output in_valid, in_op, in_src, in_dst, in_pos, in_size, out_ready,
        input  in_ready, out_valid, out_data, out_err, busy
    );

    modport slave (
        input  in_valid, in_op, in_src, in_dst, in_pos, in_size, out_ready,
        output in_ready, out_valid, out_data, out_err, busy
    );

endinterface

`default_nettype wire

// File: rtl/alu_mask_rom_32.sv
// ============================================================================
// Module      : alu_mask_rom_32
// Description : Width-mask ROM: bit i set for every i <= size_i.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mask_rom_32 (
    input  wire logic [4:0]  size_i,
    output logic      [31:0] mask_o
);

    for (genvar i = 0; i < 32; i++) begin : g_mask_bit
        assign mask_o[i] = (5'(i) <= size_i);
    end

endmodule

`default_nettype wire

// File: rtl/alu_bitfield_seq.sv
// ============================================================================
// Module      : alu_bitfield_seq
// Description : Multi-cycle bitfield extract/insert using a coarse/fine
//               iterative shifter. Optional macro ALU_BFX_SIGNED_EN enables
//               sign-extending extract for op 10.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_bitfield_seq
    import alu_bitfield_seq_pkg::*;
#(
    parameter int COARSE_STEP = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_bitfield_seq_if.slave  bus
);

    localparam logic [4:0] c_STEP = 5'(COARSE_STEP);

    logic [1:0]          state_q, state_d;
    logic [4:0]          count_q, count_d;
    logic [c_DATA_W-1:0] data_q, data_d;
    logic [c_DATA_W-1:0] mask_q, mask_d;
    logic [c_DATA_W-1:0] dst_q, dst_d;
    logic                insert_q, insert_d;
    logic                err_q, err_d;
    logic                out_valid_q, out_valid_d;
    logic [c_DATA_W-1:0] out_data_q, out_data_d;
    logic                out_err_q, out_err_d;
`ifdef ALU_BFX_SIGNED_EN
    logic                sext_q, sext_d;
`endif

    logic [c_DATA_W-1:0] rom_mask;
    logic                accept;
    logic                coarse;
    logic [4:0]          count_next;
    bfx_ctrl_t           ctrl;

    alu_mask_rom_32 u_mask_rom (
        .size_i (bus.in_size),
        .mask_o (rom_mask)
    );

    assign accept     = bus.in_valid && (state_q == c_ST_IDLE);
    assign ctrl       = decode_op(bus.in_op);
    assign coarse     = (count_q >= c_STEP);
    assign count_next = coarse ? (count_q - c_STEP) : (count_q - 5'd1);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        data_d      = data_q;
        mask_d      = mask_q;
        dst_d       = dst_q;
        insert_d    = insert_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
`ifdef ALU_BFX_SIGNED_EN
        sext_d      = sext_q;
`endif
        case (state_q)
            c_ST_IDLE: begin
                if (accept) begin
                    data_d   = bus.in_src;
                    dst_d    = bus.in_dst;
                    mask_d   = rom_mask;
                    count_d  = bus.in_pos;
                    insert_d = ctrl.insert;
                    err_d    = ctrl.err;
`ifdef ALU_BFX_SIGNED_EN
                    sext_d   = (bus.in_op == c_OP_EXTRACT_S);
`endif
                    state_d  = (bus.in_pos != 5'd0) ? c_ST_SHIFT : c_ST_MASK;
                end
            end
            c_ST_SHIFT: begin
                // Insert moves field and mask up to pos; extract pulls the field down to bit 0.
                if (insert_q) begin
                    data_d = coarse ? (data_q << COARSE_STEP) : (data_q << 1);
                    mask_d = coarse ? (mask_q << COARSE_STEP) : (mask_q << 1);
                end else begin
                    data_d = coarse ? (data_q >> COARSE_STEP) : (data_q >> 1);
                end
                count_d = count_next;
                if (count_next == 5'd0) begin
                    state_d = c_ST_MASK;
                end
            end
            c_ST_MASK: begin
                if (insert_q) begin
                    data_d = (dst_q & ~mask_q) | (data_q & mask_q);
                end else begin
                    data_d = data_q & mask_q;
`ifdef ALU_BFX_SIGNED_EN
                    // Topmost mask bit marks the field's sign bit.
                    if (sext_q && |(data_q & mask_q & ~(mask_q >> 1))) begin
                        data_d = (data_q & mask_q) | ~mask_q;
                    end
`endif
                end
                state_d = c_ST_DONE;
            end
            c_ST_DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = data_q;
                    out_err_d   = err_q;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = c_ST_IDLE;
                end
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= c_ST_IDLE;
            count_q     <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            dst_q       <= '0;
            insert_q    <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
`ifdef ALU_BFX_SIGNED_EN
            sext_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            dst_q       <= dst_d;
            insert_q    <= insert_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
`ifdef ALU_BFX_SIGNED_EN
            sext_q      <= sext_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == c_ST_IDLE);
    assign bus.busy      = (state_q != c_ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_bitfield_seq.sv
// ============================================================================
// Module      : tb_alu_bitfield_seq
// Description : Directed self-checking bench for alu_bitfield_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_bitfield_seq;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    alu_bitfield_seq_if bus ();

    alu_bitfield_seq #(.COARSE_STEP(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_op(input logic [1:0] op, input logic [31:0] src, input logic [31:0] dst,
                          input logic [4:0] pos, input logic [4:0] size, input bit early,
                          output logic [31:0] data, output logic err, output int lat);
        bus.in_op     = op;
        bus.in_src    = src;
        bus.in_dst    = dst;
        bus.in_pos    = pos;
        bus.in_size   = size;
        bus.in_valid  = 1'b1;
        bus.out_ready = early;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        data = bus.out_data;
        err  = bus.out_err;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        tests++; if (bus.out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data got %h exp 0", bus.out_data); end
        tests++; if (bus.out_err !== 1'b0) begin fails++; $display("FAIL reset_out_err got %b exp 0", bus.out_err); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    endtask

    task automatic test_extract();
        logic [31:0] d; logic e; int l;
        run_op(2'b00, 32'hDEADBEEF, 32'h0, 5'd8, 5'd7, 1'b0, d, e, l);
        tests++; if (d !== 32'h000000BE) begin fails++; $display("FAIL extract_data got %h exp 000000be", d); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL extract_err got %b exp 0", e); end
        tests++; if (l !== 3) begin fails++; $display("FAIL extract_latency got %0d exp 3", l); end
        run_op(2'b00, 32'hCAFEF00D, 32'h0, 5'd0, 5'd31, 1'b0, d, e, l);
        tests++; if (d !== 32'hCAFEF00D) begin fails++; $display("FAIL extract_full_data got %h exp cafef00d", d); end
        tests++; if (l !== 2) begin fails++; $display("FAIL extract_pos0_latency got %0d exp 2", l); end
    endtask

    task automatic test_insert();
        logic [31:0] d; logic e; int l;
        run_op(2'b01, 32'h00000005, 32'hFFFFFFFF, 5'd13, 5'd3, 1'b0, d, e, l);
        tests++; if (d !== 32'hFFFEBFFF) begin fails++; $display("FAIL insert_data got %h exp fffebfff", d); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL insert_err got %b exp 0", e); end
        tests++; if (l !== 8) begin fails++; $display("FAIL insert_latency got %0d exp 8", l); end
    endtask

    task automatic test_cross31();
        logic [31:0] d; logic e; int l;
        run_op(2'b00, 32'h80000000, 32'h0, 5'd28, 5'd7, 1'b0, d, e, l);
        tests++; if (d !== 32'h00000008) begin fails++; $display("FAIL cross_extract_data got %h exp 00000008", d); end
        tests++; if (l !== 9) begin fails++; $display("FAIL cross_extract_latency got %0d exp 9", l); end
        run_op(2'b01, 32'h000000A5, 32'h12345678, 5'd28, 5'd7, 1'b0, d, e, l);
        tests++; if (d !== 32'h52345678) begin fails++; $display("FAIL cross_insert_data got %h exp 52345678", d); end
    endtask

    task automatic test_signed();
        logic [31:0] d; logic e; int l;
        run_op(2'b10, 32'h00000F00, 32'h0, 5'd8, 5'd3, 1'b0, d, e, l);
`ifdef ALU_BFX_SIGNED_EN
        tests++; if (d !== 32'hFFFFFFFF) begin fails++; $display("FAIL signed_neg_data got %h exp ffffffff", d); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL signed_neg_err got %b exp 0", e); end
`else
        tests++; if (d !== 32'h0000000F) begin fails++; $display("FAIL signed_neg_data got %h exp 0000000f", d); end
        tests++; if (e !== 1'b1) begin fails++; $display("FAIL signed_neg_err got %b exp 1", e); end
`endif
        run_op(2'b10, 32'h00000700, 32'h0, 5'd8, 5'd3, 1'b0, d, e, l);
        tests++; if (d !== 32'h00000007) begin fails++; $display("FAIL signed_pos_data got %h exp 00000007", d); end
    endtask

    task automatic test_reserved();
        logic [31:0] d; logic e; int l;
        run_op(2'b11, 32'hDEADBEEF, 32'h0, 5'd8, 5'd7, 1'b0, d, e, l);
        tests++; if (d !== 32'h000000BE) begin fails++; $display("FAIL rsvd_data got %h exp 000000be", d); end
        tests++; if (e !== 1'b1) begin fails++; $display("FAIL rsvd_err got %b exp 1", e); end
    endtask

    task automatic test_ready_early();
        logic [31:0] d; logic e; int l;
        run_op(2'b00, 32'h0000F0F0, 32'h0, 5'd4, 5'd3, 1'b1, d, e, l);
        tests++; if (d !== 32'h0000000F) begin fails++; $display("FAIL early_ready_data got %h exp 0000000f", d); end
        tests++; if (l !== 6) begin fails++; $display("FAIL early_ready_latency got %0d exp 6", l); end
    endtask

    task automatic test_backpressure();
        int l;
        bus.in_op = 2'b00; bus.in_src = 32'hDEADBEEF; bus.in_dst = 32'h0;
        bus.in_pos = 5'd8; bus.in_size = 5'd7; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        l = 0;
        while (!bus.out_valid && l < 100) begin @(posedge clk); #1; l++; end
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_wait_valid got %b exp 1", bus.out_valid); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h000000BE || bus.in_ready !== 1'b0) begin
                fails++; $display("FAIL bp_hold cyc %0d valid %b data %h ready %b exp 1 000000be 0",
                                  i, bus.out_valid, bus.out_data, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL bp_release valid %b ready %b busy %b exp 0 1 0", bus.out_valid, bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic e; int l;
        run_op(2'b01, 32'h00000003, 32'h00000000, 5'd1, 5'd1, 1'b0, d, e, l);
        tests++; if (d !== 32'h00000006 || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL b2b_first data %h ready %b exp 00000006 1", d, bus.in_ready);
        end
        run_op(2'b00, 32'hA5A5A5A5, 32'h0, 5'd16, 5'd15, 1'b0, d, e, l);
        tests++; if (d !== 32'h0000A5A5 || l !== 4) begin
            fails++; $display("FAIL b2b_second data %h lat %0d exp 0000a5a5 4", d, l);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] d; logic e; int l;
        bus.in_op = 2'b00; bus.in_src = 32'hFFFFFFFF; bus.in_dst = 32'h0;
        bus.in_pos = 5'd28; bus.in_size = 5'd3; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL midrst_busy_before got %b exp 1", bus.busy); end
        rst_n = 1'b0;
        #1;
        tests++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL midrst_async valid %b busy %b ready %b exp 0 0 1", bus.out_valid, bus.busy, bus.in_ready);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'b00, 32'hDEADBEEF, 32'h0, 5'd8, 5'd7, 1'b0, d, e, l);
        tests++; if (d !== 32'h000000BE || l !== 3) begin
            fails++; $display("FAIL midrst_next data %h lat %0d exp 000000be 3", d, l);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_src = '0; bus.in_dst = '0;
        bus.in_pos = '0; bus.in_size = '0; bus.out_ready = 1'b0;
        #1;
        test_reset();
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        test_extract();
        test_insert();
        test_cross31();
        test_signed();
        test_reserved();
        test_ready_early();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
